// File: rtl/memory_access.sv
// memory_access: pipeline memory stage with a two-state (IDLE/WAIT) request handshake.
// Non-memory ops pass through in one cycle. A load or store issues a registered
// request and stalls the earlier stages until mem_ack arrives.
// Optional feature: define MEMORY_ACCESS_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYCLES cycles without an ack. An abort sets the sticky mem_fault flag.
module memory_access #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] result,
    input  logic [15:0] addr,
    input  logic [15:0] store_data,
    input  logic [2:0]  opcode_out,
    input  logic [2:0]  tgt_out,
    input  logic        bubble_out,
    input  logic        halt_out,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] mem_result_out,
    output logic [2:0]  mem_tgt,
    output logic        mem_bubble_out,
    output logic        mem_halt_out,
    output logic        stall,
    output logic        mem_fault
);

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] res_q, res_d;
    logic [2:0]  tgt_q, tgt_d;
    logic        bub_q, bub_d;
    logic        halt_q, halt_d;

    logic valid;
    logic memop;
    logic is_lw;
    logic timeout_hit;

    assign valid = !bubble_out;
    assign memop = valid && (opcode_out == 3'b100 || opcode_out == 3'b101);
    assign is_lw = (opcode_out == 3'b101);

`ifdef MEMORY_ACCESS_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       fault_q, fault_d;

    assign timeout_hit = (state_q == S_WAIT) && (cnt_q == TIMEOUT_LAST) && !mem_ack;
    assign mem_fault   = fault_q;

    // Timeout counter: cleared on entry to WAIT, advances on every WAIT cycle without an ack.
    always_comb begin
        cnt_d   = cnt_q;
        fault_d = fault_q | timeout_hit;
        if (state_q == S_IDLE && memop) begin
            cnt_d = 8'd0;
        end else if (state_q == S_WAIT && !mem_ack) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Timeout counter and sticky fault flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= 8'd0;
            fault_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end
`else
    // TIMEOUT_CYCLES only matters when the timeout feature is built in.
    logic unused_timeout_param;
    assign unused_timeout_param = ^TIMEOUT_CYCLES;
    assign timeout_hit          = 1'b0;
    assign mem_fault            = 1'b0;
`endif

    // The upstream stages hold while a request is being issued or is still outstanding.
    assign stall = (state_q == S_IDLE && memop) ||
                   (state_q == S_WAIT && !mem_ack && !timeout_hit);

    // State register. A reset abandons any outstanding request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (memop) state_d = S_WAIT;
            S_WAIT: if (mem_ack || timeout_hit) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output next-values. Every bubble forces tgt to 0 so that it never forwards.
    always_comb begin
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        res_d   = res_q;
        tgt_d   = tgt_q;
        bub_d   = bub_q;
        halt_d  = halt_q;
        case (state_q)
            S_IDLE: begin
                if (memop) begin
                    req_d   = 1'b1;
                    we_d    = (opcode_out == 3'b100);
                    addr_d  = addr;
                    wdata_d = store_data;
                    bub_d   = 1'b1;
                    tgt_d   = 3'd0;
                    halt_d  = 1'b0;
                end else begin
                    req_d   = 1'b0;
                    res_d   = result;
                    tgt_d   = valid ? tgt_out : 3'd0;
                    bub_d   = bubble_out;
                    halt_d  = halt_out && valid;
                end
            end
            S_WAIT: begin
                if (mem_ack) begin
                    req_d  = 1'b0;
                    res_d  = is_lw ? mem_rdata : addr;
                    tgt_d  = is_lw ? tgt_out : 3'd0;
                    bub_d  = 1'b0;
                    halt_d = halt_out;
                end else if (timeout_hit) begin
                    req_d  = 1'b0;
                    bub_d  = 1'b1;
                    tgt_d  = 3'd0;
                    halt_d = 1'b0;
                end else begin
                    bub_d  = 1'b1;
                    tgt_d  = 3'd0;
                end
            end
            default: ;
        endcase
    end

    // Registered request and writeback outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 16'd0;
            wdata_q <= 16'd0;
            res_q   <= 16'd0;
            tgt_q   <= 3'd0;
            bub_q   <= 1'b1;
            halt_q  <= 1'b0;
        end else begin
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            res_q   <= res_d;
            tgt_q   <= tgt_d;
            bub_q   <= bub_d;
            halt_q  <= halt_d;
        end
    end

    assign mem_req        = req_q;
    assign mem_we         = we_q;
    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;
    assign mem_result_out = res_q;
    assign mem_tgt        = tgt_q;
    assign mem_bubble_out = bub_q;
    assign mem_halt_out   = halt_q;

endmodule

// File: tb/tb_memory_access.sv
// Testbench for memory_access. It runs directed steps and then a randomized
// pipeline and memory responder. A transaction-level reference model predicts the outputs.
module tb_memory_access;

    localparam int TMO = 4;
`ifdef MEMORY_ACCESS_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] result, addr, store_data;
    logic [2:0]  opcode_out, tgt_out;
    logic        bubble_out, halt_out;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] mem_result_out;
    logic [2:0]  mem_tgt;
    logic        mem_bubble_out, mem_halt_out, stall, mem_fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    memory_access #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .result(result), .addr(addr), .store_data(store_data),
        .opcode_out(opcode_out), .tgt_out(tgt_out), .bubble_out(bubble_out), .halt_out(halt_out),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_result_out(mem_result_out),
        .mem_tgt(mem_tgt), .mem_bubble_out(mem_bubble_out), .mem_halt_out(mem_halt_out),
        .stall(stall), .mem_fault(mem_fault)
    );

    // Reference model. It tracks the outstanding transaction and how long it has waited.
    bit          pending;
    int          waited;
    bit          e_req, e_we, e_bub, e_halt, e_fault;
    logic [15:0] e_addr, e_wdata, e_res;
    logic [2:0]  e_tgt;
    bit          last_stall;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic bit in_memop();
        return !bubble_out && (opcode_out == 3'd4 || opcode_out == 3'd5);
    endfunction

    function automatic bit timed_out();
        return TMO_EN && pending && !mem_ack && (waited == TMO - 1);
    endfunction

    task automatic model_reset();
        pending = 0; waited = 0;
        e_req = 0; e_we = 0; e_addr = 0; e_wdata = 0;
        e_res = 0; e_tgt = 0; e_bub = 1; e_halt = 0; e_fault = 0;
    endtask

    task automatic model_step();
        bit v;
        v = !bubble_out;
        if (rst) begin
            model_reset();
        end else if (!pending) begin
            if (in_memop()) begin
                pending = 1; waited = 0;
                e_req = 1; e_we = (opcode_out == 3'd4); e_addr = addr; e_wdata = store_data;
                e_bub = 1; e_tgt = 0; e_halt = 0;
            end else begin
                e_res = result; e_tgt = v ? tgt_out : 3'd0; e_bub = bubble_out; e_halt = halt_out && v;
            end
        end else if (mem_ack) begin
            pending = 0; e_req = 0;
            e_res = (opcode_out == 3'd5) ? mem_rdata : addr;
            e_tgt = (opcode_out == 3'd5) ? tgt_out : 3'd0;
            e_bub = 0; e_halt = halt_out;
        end else if (timed_out()) begin
            pending = 0; e_req = 0; e_fault = 1; e_bub = 1; e_tgt = 0; e_halt = 0;
        end else begin
            waited++;
        end
    endtask

    // One clock: check stall before the edge, advance the model, then check the registered outputs.
    task automatic cycle();
        bit es;
        #1;
        es = (!pending && in_memop()) || (pending && !mem_ack && !timed_out());
        check("stall", 16'(stall), 16'(es));
        last_stall = es;
        model_step();
        @(posedge clk);
        #1;
        check("mem_req", 16'(mem_req), 16'(e_req));
        check("mem_we", 16'(mem_we), 16'(e_we));
        check("mem_addr", mem_addr, e_addr);
        check("mem_wdata", mem_wdata, e_wdata);
        check("mem_result_out", mem_result_out, e_res);
        check("mem_tgt", 16'(mem_tgt), 16'(e_tgt));
        check("mem_bubble_out", 16'(mem_bubble_out), 16'(e_bub));
        check("mem_halt_out", 16'(mem_halt_out), 16'(e_halt));
        check("mem_fault", 16'(mem_fault), 16'(e_fault));
        $display("t=%0t rst=%0b op=%0d bub=%0b ack=%0b | req=%0b we=%0b addr=%h res=%h tgt=%0d mbub=%0b stall=%0b fault=%0b",
                 $time, rst, opcode_out, bubble_out, mem_ack, mem_req, mem_we, mem_addr,
                 mem_result_out, mem_tgt, mem_bubble_out, stall, mem_fault);
        @(negedge clk);
    endtask

    task automatic drive(input logic [2:0] op, input logic bub, input logic [15:0] res,
                         input logic [15:0] a, input logic [15:0] sd, input logic [2:0] tg,
                         input logic hlt);
        opcode_out = op; bubble_out = bub; result = res; addr = a;
        store_data = sd; tgt_out = tg; halt_out = hlt;
    endtask

    initial begin
        rst = 1; mem_ack = 0; mem_rdata = 16'h0;
        drive(3'd0, 1'b1, 16'h0, 16'h0, 16'h0, 3'd0, 1'b0);
        model_reset();
        @(negedge clk);
        cycle();
        cycle();
        rst = 0;

        // Non-memory op with 1-cycle latency
        drive(3'd0, 1'b0, 16'h1234, 16'h0, 16'h0, 3'd3, 1'b0);
        cycle();
        check("alu_result", mem_result_out, 16'h1234);
        check("alu_tgt", 16'(mem_tgt), 16'd3);

        // Load with the ack on the third WAIT cycle
        drive(3'd5, 1'b0, 16'h0, 16'h0040, 16'h0, 3'd6, 1'b0);
        cycle();
        check("lw_addr", mem_addr, 16'h0040);
        cycle();
        cycle();
        mem_ack = 1; mem_rdata = 16'hBEEF;
        cycle();
        mem_ack = 0;
        check("lw_result", mem_result_out, 16'hBEEF);
        check("lw_tgt", 16'(mem_tgt), 16'd6);

        // Store with the ack on the first WAIT cycle
        drive(3'd4, 1'b0, 16'h0, 16'h0010, 16'h00AA, 3'd5, 1'b0);
        cycle();
        check("sw_wdata", mem_wdata, 16'h00AA);
        mem_ack = 1;
        cycle();
        mem_ack = 0;
        check("sw_tgt", 16'(mem_tgt), 16'd0);

        // A back-to-back load must issue only after a request-low cycle
        drive(3'd5, 1'b0, 16'h0, 16'h0022, 16'h0, 3'd1, 1'b0);
        cycle();
        check("b2b_req", 16'(mem_req), 16'd1);

        // Reset in the second WAIT cycle, together with an ack that must be ignored
        cycle();
        rst = 1; mem_ack = 1;
        cycle();
        rst = 0;
        drive(3'd0, 1'b1, 16'h0, 16'h0, 16'h0, 3'd0, 1'b0);
        cycle();
        mem_ack = 0;
        check("rst_req", 16'(mem_req), 16'd0);

        // Halt on a non-memory op, and halt suppressed on a bubble
        drive(3'd1, 1'b0, 16'h5555, 16'h0, 16'h0, 3'd2, 1'b1);
        cycle();
        drive(3'd4, 1'b1, 16'h6666, 16'h0, 16'h0, 3'd2, 1'b1);
        cycle();

`ifdef MEMORY_ACCESS_TIMEOUT_EN
        // Load that never gets an ack aborts after TMO WAIT cycles
        drive(3'd5, 1'b0, 16'h0, 16'h0080, 16'h0, 3'd4, 1'b0);
        for (int i = 0; i < TMO + 1; i++) cycle();
        check("tmo_fault", 16'(mem_fault), 16'd1);
        check("tmo_bub", 16'(mem_bubble_out), 16'd1);
        rst = 1;
        cycle();
        rst = 0;
`endif

        // Randomized pipeline and memory responder. Inputs are held while stalled.
        last_stall = 0;
        for (int n = 0; n < 400; n++) begin
            if (!last_stall) begin
                drive(3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0),
                      16'($urandom), 16'($urandom), 16'($urandom),
                      3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0));
            end
            mem_ack   = ($urandom_range(0, 2) == 0);
            mem_rdata = 16'($urandom);
            rst       = ($urandom_range(0, 60) == 0);
            cycle();
        end
        rst = 0; mem_ack = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
